// File: rtl/freq_div_multi.sv
// Multi-channel programmable 50%-duty clock divider with per-channel shadowed half-period.
// Optional FREQ_DIV_SYNC_EN adds a sync input that phase-aligns all channels.
module freq_div_multi #(
    parameter int CH       = 4,
    parameter int CNT_W    = 27,
    parameter int DEF_HALF = 5000000,
    localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
`ifdef FREQ_DIV_SYNC_EN
    input  logic             sync,
`endif
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_half,
    output logic [CH-1:0]    signal,
    output logic [CH-1:0]    tick
);

    logic [CNT_W-1:0] cnt       [CH];
    logic [CNT_W-1:0] half      [CH];
    logic [CNT_W-1:0] pend_half [CH];
    logic [CH-1:0]    pend;
    logic [CH-1:0]    hit;
    logic [CH-1:0]    wrap;
    logic [CH-1:0]    wr;
    logic [31:0]      cfg_ch_ext;

    assign cfg_ch_ext = 32'(cfg_ch);

    // A half-period of 0 behaves as 1, so its wrap point is cnt==0.
    always_comb begin
        hit  = '0;
        wrap = '0;
        for (int i = 0; i < CH; i++) begin
            hit[i]  = (cfg_ch_ext == 32'(i));
            wrap[i] = (half[i] == '0) ? (cnt[i] == '0)
                                      : (cnt[i] == half[i] - 1'b1);
        end
    end

    // Out-of-range channels match no hit bit, so they are always ready and discarded.
    assign cfg_ready = ~|(pend & hit);
    assign wr        = hit & {CH{cfg_valid & cfg_ready}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                cnt[i]       <= '0;
                half[i]      <= CNT_W'(DEF_HALF);
                pend_half[i] <= '0;
            end
            pend   <= '0;
            signal <= '0;
            tick   <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
`ifdef FREQ_DIV_SYNC_EN
                if (sync) begin
                    cnt[i]    <= '0;
                    signal[i] <= 1'b0;
                    tick[i]   <= 1'b0;
                    if (pend[i]) begin
                        half[i] <= pend_half[i];
                        pend[i] <= 1'b0;
                    end
                end else
`endif
                if (en) begin
                    if (wrap[i]) begin
                        cnt[i]    <= '0;
                        signal[i] <= ~signal[i];
                        tick[i]   <= 1'b1;
                        if (pend[i]) begin
                            half[i] <= pend_half[i];
                            pend[i] <= 1'b0;
                        end
                    end else begin
                        cnt[i]  <= cnt[i] + 1'b1;
                        tick[i] <= 1'b0;
                    end
                end else begin
                    tick[i] <= 1'b0;
                end
                // A write is only accepted while pend is clear, so it never collides with an apply.
                if (wr[i]) begin
                    pend[i]      <= 1'b1;
                    pend_half[i] <= cfg_half;
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_div_multi.sv
// Scoreboard bench for freq_div_multi: an event-scheduled reference model predicts
// signal/tick per edge; a monitor process pops and compares after each clock edge.
module tb_freq_div_multi;

    localparam int CH       = 3;
    localparam int CNT_W    = 8;
    localparam int DEF_HALF = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             sync = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [1:0]       cfg_ch = '0;
    logic [CNT_W-1:0] cfg_half = '0;
    logic [CH-1:0]    signal;
    logic [CH-1:0]    tick;

    int checks = 0;
    int errors = 0;

    freq_div_multi #(.CH(CH), .CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
`ifdef FREQ_DIV_SYNC_EN
        .sync(sync),
`endif
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_half(cfg_half),
        .signal(signal),
        .tick(tick)
    );

    always #5 clk = ~clk;

    // Reference model: each channel toggles at an absolute count of enabled edges.
    int m_en_edges;
    int m_half      [CH];
    int m_pend_half [CH];
    int m_next      [CH];
    bit m_pend      [CH];
    bit m_sig       [CH];
    bit m_tick      [CH];

    logic [2*CH-1:0] exp_q[$];

    function automatic int eff(input int h);
        return (h == 0) ? 1 : h;
    endfunction

    task automatic model_reset();
        m_en_edges = 0;
        for (int i = 0; i < CH; i++) begin
            m_half[i] = DEF_HALF;
            m_pend_half[i] = 0;
            m_pend[i] = 1'b0;
            m_sig[i] = 1'b0;
            m_tick[i] = 1'b0;
            m_next[i] = eff(DEF_HALF);
        end
    endtask

    task automatic model_edge(input bit e, input bit acc, input int ch, input int h);
        logic [2*CH-1:0] ex;
        if (e) m_en_edges++;
        for (int i = 0; i < CH; i++) begin
            m_tick[i] = 1'b0;
            if (e && m_en_edges == m_next[i]) begin
                m_sig[i] = ~m_sig[i];
                m_tick[i] = 1'b1;
                if (m_pend[i]) begin
                    m_half[i] = m_pend_half[i];
                    m_pend[i] = 1'b0;
                end
                m_next[i] = m_en_edges + eff(m_half[i]);
            end
        end
        if (acc && ch < CH) begin
            m_pend[ch] = 1'b1;
            m_pend_half[ch] = h;
        end
        for (int i = 0; i < CH; i++) begin
            ex[i] = m_sig[i];
            ex[CH+i] = m_tick[i];
        end
        exp_q.push_back(ex);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, check cfg_ready, predict the next edge.
    task automatic step(input bit e, input bit v, input logic [1:0] ch,
                        input logic [CNT_W-1:0] h, output bit acc);
        bit exp_rdy;
        @(negedge clk);
        en = e;
        cfg_valid = v;
        cfg_ch = ch;
        cfg_half = h;
        #1;
        exp_rdy = 1'b1;
        if (int'(ch) < CH) exp_rdy = ~m_pend[ch];
        check("cfg_ready", 32'(cfg_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        model_edge(e, acc, int'(ch), int'(h));
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 2'd0, '0, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b0;
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("reset_signal", 32'(signal), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compares every registered output against the scoreboard.
    initial begin
        logic [2*CH-1:0] ex;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                check("signal", 32'(signal), 32'(ex[CH-1:0]));
                check("tick", 32'(tick), 32'(ex[2*CH-1:CH]));
            end
        end
    end

    initial begin
        bit acc;
        bit stall;
        bit e;
        bit hv;
        logic [1:0] hc;
        logic [CNT_W-1:0] hh;
        int waited;

        model_reset();
        repeat (3) @(negedge clk);
        check("reset_signal", 32'(signal), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1'b1;

        idle(20);
        step(1'b1, 1'b1, 2'd1, 8'd2, acc);
        idle(20);

        // Back-to-back writes: the second one must stall until the first applies.
        step(1'b1, 1'b1, 2'd0, 8'd3, acc);
        waited = 0;
        do begin
            step(1'b1, 1'b1, 2'd0, 8'd6, acc);
            waited++;
        end while (!acc && waited < 20);
        check("b2b_accept", 32'(acc), 32'd1);
        idle(30);

        step(1'b1, 1'b1, 2'd2, 8'd0, acc);
        step(1'b1, 1'b1, 2'd1, 8'd1, acc);
        idle(20);
        step(1'b1, 1'b1, 2'd3, 8'd5, acc);
        idle(10);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 2'd0, '0, acc);
        idle(10);

        // Reset while a write is pending: the update must be lost.
        step(1'b1, 1'b1, 2'd0, 8'd2, acc);
        idle(1);
        do_reset();
        idle(20);

        stall = 1'b0;
        hv = 1'b0;
        hc = '0;
        hh = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!stall) begin
                hv = ($urandom_range(0, 3) == 0);
                hc = 2'($urandom_range(0, 3));
                hh = CNT_W'($urandom_range(0, 7));
            end
            e = ($urandom_range(0, 15) != 0);
            step(e, hv, hc, hh, acc);
            stall = hv && !acc;
            if (n == 1500) begin
                do_reset();
                stall = 1'b0;
            end
        end

        idle(2);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
